// File: rtl/bin2bcd_seq_pkg.sv
// Shared types and constants for the sequential binary-to-BCD converter.
package bin2bcd_seq_pkg;

  localparam int BIN_W_DEF  = 27;
  localparam int DIGITS_DEF = 8;

  typedef logic [3:0] bcd_nib_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } conv_state_t;

  localparam bcd_nib_t SAT_DIGIT = 4'h9;

endpackage

// File: rtl/bin2bcd_seq_digit_adj.sv
// Double-dabble digit correction: a BCD digit of 5 or more gets +3 before the shift.
module bcd_digit_adj
  import bin2bcd_seq_pkg::*;
(
  input  bcd_nib_t d_i,
  output bcd_nib_t d_o
);

  always_comb begin
    d_o = d_i;
    if (d_i >= 4'd5) d_o = d_i + 4'd3;
  end

endmodule

// File: rtl/bin2bcd_seq.sv
// Iterative double-dabble converter, one bit per clock, results held between conversions.
// Leading-zero blanking is built only when BIN2BCD_BLANK_LZ_EN is defined.
module bin2bcd_seq
  import bin2bcd_seq_pkg::*;
#(
  parameter int BIN_W  = BIN_W_DEF,
  parameter int DIGITS = DIGITS_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [BIN_W-1:0]      in_bin,
  output logic [4*DIGITS-1:0]   bcd_out,
  output logic                  ovf,
  output logic                  out_valid,
  output logic [DIGITS-1:0]     blank_mask
);

  localparam int CW = $clog2(BIN_W + 1);

  conv_state_t         state_q, state_d;
  logic [BIN_W-1:0]    bin_q, bin_d;
  logic [4*DIGITS-1:0] work_q, work_d;
  logic [4*DIGITS-1:0] work_adj;
  logic                acc_q, acc_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [4*DIGITS-1:0] bcd_q, bcd_d;
  logic                ovf_q, ovf_d;
  logic                vld_q, vld_d;
  logic [DIGITS-1:0]   blank_q, blank_d;
  logic [DIGITS-1:0]   blank_calc;

  for (genvar g = 0; g < DIGITS; g++) begin : g_adj
    bcd_digit_adj u_adj (
      .d_i (work_q[4*g +: 4]),
      .d_o (work_adj[4*g +: 4])
    );
  end

`ifdef BIN2BCD_BLANK_LZ_EN
  // Walk down from the top digit; a digit blanks while everything above it is zero.
  always_comb begin
    logic zero_above;
    blank_calc = '0;
    zero_above = 1'b1;
    for (int k = DIGITS - 1; k >= 1; k--) begin
      zero_above    = zero_above && (work_q[4*k +: 4] == 4'd0);
      blank_calc[k] = zero_above && !acc_q;
    end
  end
`else
  assign blank_calc = '0;
`endif

  always_comb begin
    state_d = state_q;
    bin_d   = bin_q;
    work_d  = work_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    bcd_d   = bcd_q;
    ovf_d   = ovf_q;
    vld_d   = 1'b0;
    blank_d = blank_q;
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          bin_d   = in_bin;
          work_d  = '0;
          acc_d   = 1'b0;
          cnt_d   = CW'(BIN_W - 1);
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        work_d = {work_adj[4*DIGITS-2:0], bin_q[BIN_W-1]};
        bin_d  = {bin_q[BIN_W-2:0], 1'b0};
        acc_d  = acc_q | work_adj[4*DIGITS-1];
        if (cnt_q == '0) state_d = DONE;
        else             cnt_d   = cnt_q - 1'b1;
      end
      DONE: begin
        vld_d   = 1'b1;
        state_d = IDLE;
        blank_d = blank_calc;
        if (acc_q) begin
          bcd_d = {DIGITS{SAT_DIGIT}};
          ovf_d = 1'b1;
        end else begin
          bcd_d = work_q;
          ovf_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      bin_q   <= '0;
      work_q  <= '0;
      acc_q   <= 1'b0;
      cnt_q   <= '0;
      bcd_q   <= '0;
      ovf_q   <= 1'b0;
      vld_q   <= 1'b0;
      blank_q <= '0;
    end else begin
      state_q <= state_d;
      bin_q   <= bin_d;
      work_q  <= work_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      bcd_q   <= bcd_d;
      ovf_q   <= ovf_d;
      vld_q   <= vld_d;
      blank_q <= blank_d;
    end
  end

  assign in_ready   = (state_q == IDLE);
  assign bcd_out    = bcd_q;
  assign ovf        = ovf_q;
  assign out_valid  = vld_q;
  assign blank_mask = blank_q;

endmodule
